// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the fetch sequencer
// (FSM state encoding, HALT opcode default, timeout counter width).
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_HALTED = 3'd5
  } fetch_state_e;

  localparam logic [4:0] HALT_OP_DEFAULT = 5'b00000;
  localparam int         TMO_W           = 8;

  // True when the opcode field of an instruction matches the halt opcode.
  function automatic logic is_halt(input logic [15:0] inst, input logic [4:0] op);
    return (inst[15:11] == op);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory, decode and control signals of the
// fetch sequencer. master = fetch_ctrl side, slave = memory/decode/pc side.
interface fetch_ctrl_if;

  logic        imem_req;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        id_valid;
  logic [15:0] id_inst;
  logic        id_ready;
  logic        flush;
  logic        pc_en;
  logic        halted;
  logic        tmo_err;

  modport master (
    output imem_req, id_valid, id_inst, pc_en, halted, tmo_err,
    input  imem_done, imem_rdata, id_ready, flush
  );

  modport slave (
    input  imem_req, id_valid, id_inst, pc_en, halted, tmo_err,
    output imem_done, imem_rdata, id_ready, flush
  );

endinterface

// File: rtl/fetch_tmo.sv
// fetch_tmo: memory-wait timeout counter (clear / enable / terminal count).
// Only built when FETCH_CTRL_TIMEOUT_EN is defined, matching its single use.
`ifdef FETCH_CTRL_TIMEOUT_EN
module fetch_tmo
  import fetch_ctrl_pkg::*;
#(
  parameter logic [TMO_W-1:0] TMO_CYCLES = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Next count: clear wins over counting; hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {TMO_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {TMO_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: this enabled cycle is the TMO_CYCLES-th without a response.
  assign tc = en && (cnt_q == (TMO_CYCLES - {{(TMO_W-1){1'b0}}, 1'b1}));

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between pc, instruction memory and decode.
// Optional memory-wait timeout enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [4:0]       HALT_OP    = HALT_OP_DEFAULT,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [15:0]  id_inst_q, id_inst_d;
  logic         id_valid_q, id_valid_d;
  logic         halted_q, halted_d;
  logic         tmo_err_q, tmo_err_d;
  logic         imem_req_s;
  logic         pc_en_s;
  logic         tmo_tc_s;

`ifdef FETCH_CTRL_TIMEOUT_EN
  logic tmo_clr_s;
  logic tmo_en_s;
  logic in_wait_s;

  // Timeout counter controls: clear on entry to WAIT/DRAIN, count idle wait cycles.
  always_comb begin
    in_wait_s = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    tmo_clr_s = ((state_d == ST_WAIT) || (state_d == ST_DRAIN)) && (state_d != state_q);
    tmo_en_s  = in_wait_s && !bus.imem_done;
  end

  fetch_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr_s),
    .en  (tmo_en_s),
    .tc  (tmo_tc_s)
  );
`else
  logic unused_tmo_cfg_s;
  assign tmo_tc_s         = 1'b0;
  assign unused_tmo_cfg_s = ^TMO_CYCLES;
`endif

  // Next-state, id_inst capture and combinational strobes.
  always_comb begin
    state_d    = state_q;
    id_inst_d  = id_inst_q;
    tmo_err_d  = tmo_err_q;
    imem_req_s = 1'b0;
    pc_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.flush) begin
          state_d = ST_REQ;
        end else begin
          imem_req_s = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_done) begin
          if (bus.flush) begin
            state_d = ST_REQ;
          end else begin
            id_inst_d = bus.imem_rdata;
            state_d   = ST_HOLD;
          end
        end else if (tmo_tc_s) begin
          tmo_err_d = 1'b1;
          state_d   = ST_HALTED;
        end else if (bus.flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_done) begin
          state_d = ST_REQ;
        end else if (tmo_tc_s) begin
          tmo_err_d = 1'b1;
          state_d   = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (bus.flush) begin
          state_d = ST_REQ;
        end else if (bus.id_ready) begin
          if (is_halt(id_inst_q, HALT_OP)) begin
            state_d = ST_HALTED;
          end else begin
            pc_en_s = 1'b1;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    id_valid_d = (state_d == ST_HOLD);
    halted_d   = (state_d == ST_HALTED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_inst_q  <= 16'h0000;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      halted_q   <= halted_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign bus.imem_req = imem_req_s;
  assign bus.pc_en    = pc_en_s;
  assign bus.id_valid = id_valid_q;
  assign bus.id_inst  = id_inst_q;
  assign bus.halted   = halted_q;
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the single-issue 16-bit core. Sits between the `pc` block, the variable-latency instruction memory, and decode. Issues one instruction-memory read per instruction, holds the returned word until decode accepts it, then pulses the PC write-enable so the PC advances, branches or jumps on the accepted instruction. It also handles flush and HALT.

## Interface
Parameters:
- HALT_OP, 5'b00000: opcode in inst[15:11] that halts fetch.
- TMO_CYCLES, 8'd255: memory-wait limit; used only with the timeout feature.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- imem_req  out  1  one-cycle read strobe at the PC's current `addr`.
- imem_done  in  1  one-cycle strobe; imem_rdata is valid this cycle. Memory contract: earliest one cycle after imem_req.
- imem_rdata  in  16  fetched instruction.
- id_valid  out  1  id_inst holds an instruction for decode.
- id_inst  out  16  held instruction; also drives the `pc` block `inst` input.
- id_ready  in  1  decode accepts id_inst this cycle.
- flush  in  1  abort the current fetch and refetch from the current PC.
- pc_en  out  1  write-enable to the `pc` register; combinational, at most one cycle per instruction.
- halted  out  1  HALT retired; sticky until rst.
- tmo_err  out  1  memory-wait timeout; sticky until rst.

## Operation
States:
- IDLE:
  - Entered on rst.
  - Unconditional transition to REQ.
- REQ:
  - imem_req=1, then go to WAIT.
  - flush in REQ suppresses imem_req; stay in REQ.
  - imem_done in REQ is ignored.
- WAIT:
  - imem_done: latch imem_rdata into id_inst, then go to HOLD.
  - flush without imem_done: go to DRAIN.
  - flush with imem_done: discard the data, then go to REQ.
- DRAIN:
  - Wait for imem_done, discard the data, then go to REQ.
  - flush in DRAIN has no further effect.
- HOLD:
  - id_valid=1.
  - id_ready && !flush && inst[15:11]!=HALT_OP: pc_en=1 in the same cycle, then go to REQ.
  - id_ready && !flush && inst[15:11]==HALT_OP: pc_en=0, then go to HALTED.
  - flush (overrides id_ready): pc_en=0, then go to REQ; id_valid drops the next cycle.
- HALTED:
  - halted=1, all strobes 0.
  - Ignores flush, imem_done and id_ready; exits only on rst.

Rules:
- id_inst is stable while id_valid=1 and is updated only on an accepted imem_done.
- pc_en is asserted only from HOLD, so the `pc` block always sees the instruction that caused the advance.
- Reset mid-operation: any state goes to IDLE. An imem_done belonging to a pre-reset request arrives in IDLE or REQ and is dropped by the ignore rule above.

## Timing
- Reset values:
  - state=IDLE.
  - imem_req=0, id_valid=0, id_inst=16'h0000, pc_en=0, halted=0, tmo_err=0.
- First imem_req is asserted 2 cycles after rst deasserts (IDLE, then REQ).
- With 1-cycle memory and id_ready held high, the sequence is:
  - cycle N: REQ.
  - cycle N+1: WAIT, imem_done.
  - cycle N+2: HOLD, id_valid, pc_en.
  - cycle N+3: REQ again.
  - Throughput: one instruction per 3 cycles.
- Every extra memory wait cycle adds one cycle. Every cycle id_ready stays low in HOLD adds one cycle.
- id_valid is registered (asserted in HOLD). pc_en is combinational from state, id_ready, flush and id_inst.

## Configuration
- Macro: FETCH_CTRL_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT or DRAIN and increments each cycle spent there without imem_done.
  - When the count reaches TMO_CYCLES: tmo_err=1 and halted=1 from the next cycle, state goes to HALTED.
  - imem_done in the limit cycle wins: no error.
- Undefined:
  - No counter logic; tmo_err is tied to 0.
  - A missing imem_done stalls forever in WAIT or DRAIN.

## Structure
- Package fetch_ctrl_pkg:
  - state encoding (IDLE, REQ, WAIT, DRAIN, HOLD, HALTED, 3 bits).
  - HALT_OP default.
  - TMO width constant.
- Sub-module fetch_tmo:
  - Clear/enable/terminal-count counter.
  - Instantiated only under FETCH_CTRL_TIMEOUT_EN.
- Top level: FSM register, id_inst register, output decode.

## Test plan
- Reset, then 1-cycle memory returning 16'h4A21 with id_ready=1:
  - imem_req in the 2nd cycle after reset.
  - id_valid with id_inst=16'h4A21 and pc_en=1 two cycles later.
  - Next imem_req on the following cycle.
- Decode backpressure, id_ready=0 for 4 cycles in HOLD: id_valid and id_inst held, pc_en=0 throughout; a single pc_en on the first id_ready=1 cycle.
- Flush one cycle after imem_req with 3-cycle memory:
  - Goes to DRAIN; the returned data is never presented.
  - A new imem_req follows the cycle after imem_done; no pc_en for the dropped word.
- Flush and id_ready together in HOLD: pc_en=0, id_valid low the next cycle, refetch issued.
- HALT instruction 16'h0000 accepted:
  - pc_en=0, halted=1 the next cycle.
  - No further imem_req over 20 cycles despite flush pulses.
  - rst clears halted.
- With FETCH_CTRL_TIMEOUT_EN and TMO_CYCLES=8, memory never responds: tmo_err=1 and halted=1 after 8 WAIT cycles. Repeat with imem_done arriving in the 8th wait cycle: no error.
